// File: rtl/if_fetch_pair_if.sv
// Instruction-memory bus between the dual-issue fetch stage and a synchronous
// two-port instruction memory. Read data is valid one cycle after rd.
interface if_fetch_pair_if #(
    parameter int PC_W   = 4,
    parameter int DATA_W = 32
);
    logic              rd;
    logic [PC_W-1:0]   addr1;
    logic [PC_W-1:0]   addr2;
    logic [DATA_W-1:0] do1;
    logic [DATA_W-1:0] do2;

    modport master (
        output rd,
        output addr1,
        output addr2,
        input  do1,
        input  do2
    );

    modport slave (
        input  rd,
        input  addr1,
        input  addr2,
        output do1,
        output do2
    );
endinterface

// File: rtl/if_fetch_pair.sv
// Dual-issue fetch stage feeding an enable-less IF/ID register: two words per
// cycle, a one-entry skid buffer for hazard stalls, and redirect with IF/ID flush.
module if_fetch_pair #(
    parameter int                PC_W     = 4,
    parameter int                DATA_W   = 32,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP      = '0
) (
    input  logic                reloj,
    input  logic                resetIF_n,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    if_fetch_pair_if.master     imem,
    output logic [DATA_W-1:0]   DO1,
    output logic [DATA_W-1:0]   DO2,
    output logic [PC_W-1:0]     PC_4,
    output logic [PC_W-1:0]     PC_8,
    output logic                fetch_valid,
    output logic                resetIF
);

    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);
    localparam logic [PC_W-1:0] PC_TWO = PC_W'(2);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              pending_q, pending_d;
    logic [PC_W-1:0]   pend_pc_q, pend_pc_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_do1_q, skid_do1_d;
    logic [DATA_W-1:0] skid_do2_q, skid_do2_d;
    logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
    logic [DATA_W-1:0] do1_q, do1_d;
    logic [DATA_W-1:0] do2_q, do2_d;
    logic [PC_W-1:0]   pc4_q, pc4_d;
    logic [PC_W-1:0]   pc8_q, pc8_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              rd_en;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pending_d     = pending_q;
        pend_pc_d     = pend_pc_q;
        skid_valid_d  = skid_valid_q;
        skid_do1_d    = skid_do1_q;
        skid_do2_d    = skid_do2_q;
        skid_pc_d     = skid_pc_q;
        do1_d         = do1_q;
        do2_d         = do2_q;
        pc4_d         = pc4_q;
        pc8_d         = pc8_q;
        fetch_valid_d = fetch_valid_q;
        rd_en         = 1'b0;

        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
                if (redirect) begin
                    pc_d = redirect_pc;
                end
            end

            ST_RUN, ST_HOLD: begin
                if (redirect) begin
                    // Flush: whatever is in flight or parked belongs to the wrong path.
                    pc_d          = redirect_pc;
                    pending_d     = 1'b0;
                    skid_valid_d  = 1'b0;
                    do1_d         = NOP;
                    do2_d         = NOP;
                    fetch_valid_d = 1'b0;
                    state_d       = ST_RUN;
                end else if (stall) begin
                    if (state_q == ST_RUN && pending_q) begin
                        skid_valid_d = 1'b1;
                        skid_do1_d   = imem.do1;
                        skid_do2_d   = imem.do2;
                        skid_pc_d    = pend_pc_q;
                        pending_d    = 1'b0;
                        state_d      = ST_HOLD;
                    end
                end else begin
                    rd_en     = 1'b1;
                    pc_d      = pc_q + PC_TWO;
                    pending_d = 1'b1;
                    pend_pc_d = pc_q;
                    state_d   = ST_RUN;
                    // The parked pair is older than anything in flight, so it goes out first.
                    if (state_q == ST_HOLD && skid_valid_q) begin
                        do1_d         = skid_do1_q;
                        do2_d         = skid_do2_q;
                        pc4_d         = skid_pc_q + PC_ONE;
                        pc8_d         = skid_pc_q + PC_TWO;
                        fetch_valid_d = 1'b1;
                        skid_valid_d  = 1'b0;
                    end else if (pending_q) begin
                        do1_d         = imem.do1;
                        do2_d         = imem.do2;
                        pc4_d         = pend_pc_q + PC_ONE;
                        pc8_d         = pend_pc_q + PC_TWO;
                        fetch_valid_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge reloj or negedge resetIF_n) begin
        if (!resetIF_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            pending_q     <= 1'b0;
            pend_pc_q     <= '0;
            skid_valid_q  <= 1'b0;
            skid_do1_q    <= NOP;
            skid_do2_q    <= NOP;
            skid_pc_q     <= '0;
            do1_q         <= NOP;
            do2_q         <= NOP;
            pc4_q         <= '0;
            pc8_q         <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pending_q     <= pending_d;
            pend_pc_q     <= pend_pc_d;
            skid_valid_q  <= skid_valid_d;
            skid_do1_q    <= skid_do1_d;
            skid_do2_q    <= skid_do2_d;
            skid_pc_q     <= skid_pc_d;
            do1_q         <= do1_d;
            do2_q         <= do2_d;
            pc4_q         <= pc4_d;
            pc8_q         <= pc8_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    assign imem.rd     = rd_en;
    assign imem.addr1  = pc_q;
    assign imem.addr2  = pc_q + PC_ONE;

    assign DO1         = do1_q;
    assign DO2         = do2_q;
    assign PC_4        = pc4_q;
    assign PC_8        = pc8_q;
    assign fetch_valid = fetch_valid_q;
    assign resetIF     = (state_q == ST_BOOT) | redirect;

endmodule

// File: tb/tb_if_fetch_pair.sv
// Bench for if_fetch_pair: directed stall/redirect/reset scenarios, a queue of
// expected instruction pairs, and a negedge monitor that checks each new pair.
module tb_if_fetch_pair;

    localparam logic [31:0] NOPV = 32'h0000_0000;

    logic        reloj;
    logic        resetIF_n;
    logic        stall;
    logic        redirect;
    logic [3:0]  redirect_pc;
    logic [31:0] DO1, DO2;
    logic [3:0]  PC_4, PC_8;
    logic        fetch_valid;
    logic        resetIF;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  p4;
        logic [3:0]  p8;
    } pair_t;

    pair_t exp_q[$];

    if_fetch_pair_if #(.PC_W(4), .DATA_W(32)) bus ();

    if_fetch_pair #(
        .PC_W     (4),
        .DATA_W   (32),
        .RESET_PC (4'd0),
        .NOP      (32'h0000_0000)
    ) dut (
        .reloj       (reloj),
        .resetIF_n   (resetIF_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (bus),
        .DO1         (DO1),
        .DO2         (DO2),
        .PC_4        (PC_4),
        .PC_8        (PC_8),
        .fetch_valid (fetch_valid),
        .resetIF     (resetIF)
    );

    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    // Synchronous instruction memory holding mem[i] = 0x1000_0000 + i.
    always @(posedge reloj) begin
        if (bus.rd) begin
            bus.do1 <= 32'h1000_0000 + {28'h0, bus.addr1};
            bus.do2 <= 32'h1000_0000 + {28'h0, bus.addr2};
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before the end of stimulus");
        $fatal(1, "watchdog timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end else begin
            $display("ok   %s = %h t=%0t", nm, act, $time);
        end
    endtask

    task automatic push(input logic [31:0] d1, input logic [31:0] d2,
                        input logic [3:0] p4, input logic [3:0] p8);
        pair_t e;
        e.d1 = d1; e.d2 = d2; e.p4 = p4; e.p8 = p8;
        exp_q.push_back(e);
    endtask

    // Advance to the next cycle, drive inputs for it, then wait for the sampling edge.
    task automatic cyc(input logic st, input logic rd, input logic [3:0] rpc);
        @(posedge reloj);
        #1;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        @(negedge reloj);
    endtask

    // Monitor: a pair is new when fetch_valid rises or the visible pair changes.
    initial begin
        pair_t last;
        pair_t cur;
        pair_t e;
        logic  last_v;
        last   = '0;
        last_v = 1'b0;
        forever begin
            @(negedge reloj);
            cur.d1 = DO1; cur.d2 = DO2; cur.p4 = PC_4; cur.p8 = PC_8;
            if (fetch_valid === 1'b1 && (!last_v || cur != last)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_pair unexpected got=%h/%h pc4=%0d pc8=%0d exp=none",
                             cur.d1, cur.d2, cur.p4, cur.p8);
                end else begin
                    e = exp_q.pop_front();
                    if (cur != e) begin
                        failures++;
                        $display("FAIL sb_pair got=%h/%h pc4=%0d pc8=%0d exp=%h/%h pc4=%0d pc8=%0d",
                                 cur.d1, cur.d2, cur.p4, cur.p8, e.d1, e.d2, e.p4, e.p8);
                    end else begin
                        $display("pair %h/%h pc4=%0d pc8=%0d t=%0t", cur.d1, cur.d2, cur.p4, cur.p8, $time);
                    end
                end
            end
            last   = cur;
            last_v = (fetch_valid === 1'b1);
        end
    end

    initial begin
        resetIF_n   = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 4'd0;

        // Phase A: reset release, stall into skid, wrap, redirect with full skid.
        push(32'h1000_0000, 32'h1000_0001, 4'd1,  4'd2);
        push(32'h1000_0002, 32'h1000_0003, 4'd3,  4'd4);
        push(32'h1000_0004, 32'h1000_0005, 4'd5,  4'd6);
        push(32'h1000_0006, 32'h1000_0007, 4'd7,  4'd8);
        push(32'h1000_0008, 32'h1000_0009, 4'd9,  4'd10);
        push(32'h1000_000A, 32'h1000_000B, 4'd11, 4'd12);
        push(32'h1000_000C, 32'h1000_000D, 4'd13, 4'd14);
        push(32'h1000_000E, 32'h1000_000F, 4'd15, 4'd0);
        push(32'h1000_0000, 32'h1000_0001, 4'd1,  4'd2);
        push(32'h1000_0002, 32'h1000_0003, 4'd3,  4'd4);
        push(32'h1000_0009, 32'h1000_000A, 4'd10, 4'd11);
        // Phase B: after mid-cycle reset, then redirect to 15.
        push(32'h1000_0000, 32'h1000_0001, 4'd1,  4'd2);
        push(32'h1000_000F, 32'h1000_0000, 4'd0,  4'd1);
        push(32'h1000_0001, 32'h1000_0002, 4'd2,  4'd3);

        repeat (3) @(posedge reloj);
        @(negedge reloj);
        chk("rst_do1",   DO1, NOPV);
        chk("rst_do2",   DO2, NOPV);
        chk("rst_pc4",   {28'h0, PC_4}, 32'd0);
        chk("rst_pc8",   {28'h0, PC_8}, 32'd0);
        chk("rst_fv",    {31'h0, fetch_valid}, 32'd0);
        chk("rst_rd",    {31'h0, bus.rd}, 32'd0);

        resetIF_n = 1'b1;                       // cycle 0: BOOT
        #1;
        chk("c0_resetIF", {31'h0, resetIF}, 32'd1);
        chk("c0_rd",      {31'h0, bus.rd}, 32'd0);

        cyc(1'b0, 1'b0, 4'd0);                  // c1
        chk("c1_rd",      {31'h0, bus.rd}, 32'd1);
        chk("c1_addr1",   {28'h0, bus.addr1}, 32'd0);
        chk("c1_addr2",   {28'h0, bus.addr2}, 32'd1);
        chk("c1_resetIF", {31'h0, resetIF}, 32'd0);
        cyc(1'b0, 1'b0, 4'd0);                  // c2
        cyc(1'b0, 1'b0, 4'd0);                  // c3
        chk("c3_do1", DO1, 32'h1000_0000);
        chk("c3_do2", DO2, 32'h1000_0001);
        chk("c3_pc4", {28'h0, PC_4}, 32'd1);
        chk("c3_pc8", {28'h0, PC_8}, 32'd2);
        chk("c3_fv",  {31'h0, fetch_valid}, 32'd1);

        cyc(1'b1, 1'b0, 4'd0);                  // c4: stall, 4/5 into skid
        chk("c4_rd_stall", {31'h0, bus.rd}, 32'd0);
        cyc(1'b1, 1'b0, 4'd0);                  // c5
        cyc(1'b1, 1'b0, 4'd0);                  // c6
        chk("c6_hold_do1", DO1, 32'h1000_0002);
        chk("c6_rd_hold",  {31'h0, bus.rd}, 32'd0);
        cyc(1'b0, 1'b0, 4'd0);                  // c7: release
        chk("c7_hold_do1", DO1, 32'h1000_0002);
        chk("c7_addr1",    {28'h0, bus.addr1}, 32'd6);
        cyc(1'b0, 1'b0, 4'd0);                  // c8
        chk("c8_skid_do1", DO1, 32'h1000_0004);
        chk("c8_skid_do2", DO2, 32'h1000_0005);
        cyc(1'b0, 1'b0, 4'd0);                  // c9
        cyc(1'b0, 1'b0, 4'd0);                  // c10
        cyc(1'b0, 1'b0, 4'd0);                  // c11
        chk("c11_addr1", {28'h0, bus.addr1}, 32'd14);
        chk("c11_addr2", {28'h0, bus.addr2}, 32'd15);
        cyc(1'b0, 1'b0, 4'd0);                  // c12
        cyc(1'b0, 1'b0, 4'd0);                  // c13
        chk("c13_do1", DO1, 32'h1000_000E);
        chk("c13_pc4", {28'h0, PC_4}, 32'd15);
        chk("c13_pc8", {28'h0, PC_8}, 32'd0);
        cyc(1'b0, 1'b0, 4'd0);                  // c14
        chk("c14_do1", DO1, 32'h1000_0000);
        chk("c14_pc4", {28'h0, PC_4}, 32'd1);

        cyc(1'b1, 1'b0, 4'd0);                  // c15: stall, skid fills
        cyc(1'b1, 1'b1, 4'd9);                  // c16: redirect beats stall
        chk("c16_resetIF", {31'h0, resetIF}, 32'd1);
        chk("c16_rd",      {31'h0, bus.rd}, 32'd0);
        cyc(1'b0, 1'b0, 4'd0);                  // c17
        chk("c17_do1_nop", DO1, NOPV);
        chk("c17_do2_nop", DO2, NOPV);
        chk("c17_fv",      {31'h0, fetch_valid}, 32'd0);
        chk("c17_addr1",   {28'h0, bus.addr1}, 32'd9);
        chk("c17_rd",      {31'h0, bus.rd}, 32'd1);
        cyc(1'b0, 1'b0, 4'd0);                  // c18
        cyc(1'b0, 1'b0, 4'd0);                  // c19
        chk("c19_do1", DO1, 32'h1000_0009);
        chk("c19_do2", DO2, 32'h1000_000A);
        chk("c19_pc4", {28'h0, PC_4}, 32'd10);
        chk("c19_pc8", {28'h0, PC_8}, 32'd11);

        // Asynchronous reset asserted mid-cycle.
        @(posedge reloj);
        #2;
        resetIF_n = 1'b0;
        #1;
        chk("arst_do1",     DO1, NOPV);
        chk("arst_fv",      {31'h0, fetch_valid}, 32'd0);
        chk("arst_pc4",     {28'h0, PC_4}, 32'd0);
        chk("arst_rd",      {31'h0, bus.rd}, 32'd0);
        chk("arst_resetIF", {31'h0, resetIF}, 32'd1);
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        resetIF_n = 1'b1;                       // R0: BOOT
        #1;
        chk("r0_resetIF", {31'h0, resetIF}, 32'd1);
        cyc(1'b0, 1'b0, 4'd0);                  // R1
        chk("r1_addr1", {28'h0, bus.addr1}, 32'd0);
        chk("r1_rd",    {31'h0, bus.rd}, 32'd1);
        cyc(1'b0, 1'b0, 4'd0);                  // R2
        cyc(1'b0, 1'b1, 4'd15);                 // R3: redirect to odd/wrapping target
        chk("r3_do1",     DO1, 32'h1000_0000);
        chk("r3_resetIF", {31'h0, resetIF}, 32'd1);
        cyc(1'b0, 1'b0, 4'd0);                  // R4
        chk("r4_addr1",   {28'h0, bus.addr1}, 32'd15);
        chk("r4_addr2",   {28'h0, bus.addr2}, 32'd0);
        chk("r4_do1_nop", DO1, NOPV);
        cyc(1'b0, 1'b0, 4'd0);                  // R5
        cyc(1'b0, 1'b0, 4'd0);                  // R6
        chk("r6_do1", DO1, 32'h1000_000F);
        chk("r6_do2", DO2, 32'h1000_0000);
        chk("r6_pc4", {28'h0, PC_4}, 32'd0);
        chk("r6_pc8", {28'h0, PC_8}, 32'd1);
        cyc(1'b1, 1'b0, 4'd0);                  // R7: freeze from here on
        chk("r7_do1", DO1, 32'h1000_0001);
        chk("r7_pc4", {28'h0, PC_4}, 32'd2);
        chk("r7_pc8", {28'h0, PC_8}, 32'd3);
        repeat (3) cyc(1'b1, 1'b0, 4'd0);

        chk("sb_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
